// File: rtl/csr_stim_checker.sv
// csr_stim_checker: LFSR-driven CSR traffic engine that checks read data against a shadow model.
// Define CSR_STIM_FIRST_ERR_EN to add the sticky first-error capture outputs.

module csr_stim_checker #(
  parameter int unsigned NumAccesses = 256,
  parameter int unsigned NumShadow   = 8,
  parameter logic [11:0] AddrBase    = 12'h7C0,
  parameter logic [31:0] WrMask      = 32'hFFFF_FFFF,
  parameter int unsigned GapCycles   = 0,
  parameter logic [31:0] LfsrSeed    = 32'hACE1_2D5B,
  localparam int unsigned CntW       = $clog2(NumAccesses + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            csr_access_o,
  output logic [11:0]     csr_addr_o,
  output logic [31:0]     csr_wdata_o,
  output logic [1:0]      csr_op_o,
  output logic            csr_op_en_o,
  input  logic [31:0]     csr_rdata_i,
  input  logic            illegal_csr_insn_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            test_passed_o,
  output logic [15:0]     err_count_o,
`ifdef CSR_STIM_FIRST_ERR_EN
  output logic [11:0]     first_err_addr_o,
  output logic [31:0]     first_err_exp_o,
  output logic [31:0]     first_err_got_o,
  output logic            first_err_vld_o,
`endif
  output logic [CntW-1:0] access_count_o
);

  localparam int unsigned IdxW     = $clog2(NumShadow);
  localparam logic [31:0] LfsrPoly = 32'h8020_0003;
  localparam logic [3:0]  GapLast  = (GapCycles > 0) ? 4'(GapCycles - 1) : 4'd0;
  localparam logic [CntW-1:0] LastIssueCnt = CntW'(NumAccesses - 1);
  localparam logic [CntW-1:0] FullCnt      = CntW'(NumAccesses);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpRead,
    OpWrite,
    OpSet,
    OpClear
  } csr_op_e;

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_next;
  logic [3:0]        gap_q;
  logic [CntW-1:0]   acc_cnt_q;
  logic [15:0]       err_q;
  logic [NumShadow-1:0] valid_q;
  logic [31:0]       shadow_q [NumShadow];

  logic              issue;
  logic              start_ok;
  logic [IdxW-1:0]   idx;
  logic [11:0]       acc_addr;
  csr_op_e           acc_op;
  logic [31:0]       acc_wdata;
  logic              entry_valid;
  logic [31:0]       shadow_old;
  logic              mismatch;
  logic              err_event;
  logic [31:0]       base_val;
  logic [31:0]       wmasked;
  logic [31:0]       shadow_new;

  // Access fields are decoded straight from the current LFSR value.
  assign issue     = (state_q == StIssue);
  assign start_ok  = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign idx       = lfsr_q[IdxW-1:0];
  assign acc_addr  = AddrBase + 12'(idx);
  assign acc_op    = csr_op_e'(lfsr_q[9:8]);
  assign acc_wdata = {lfsr_q[15:0], lfsr_q[31:16]};
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrPoly : 32'h0);

  assign entry_valid = valid_q[idx];
  assign shadow_old  = shadow_q[idx];
  assign mismatch    = issue && !illegal_csr_insn_i && entry_valid && (csr_rdata_i != shadow_old);
  assign err_event   = issue && (illegal_csr_insn_i || mismatch);
  assign base_val    = entry_valid ? shadow_old : csr_rdata_i;
  assign wmasked     = acc_wdata & WrMask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    shadow_new = base_val;
    unique case (acc_op)
      OpWrite: shadow_new = (base_val & ~WrMask) | wmasked;
      OpSet:   shadow_new = base_val | wmasked;
      OpClear: shadow_new = base_val & ~wmasked;
      default: shadow_new = base_val;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StIssue;
      end
      StIssue: begin
        if (GapCycles != 0)               state_d = StGap;
        else if (acc_cnt_q == LastIssueCnt) state_d = StDone;
        else                              state_d = StIssue;
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = (acc_cnt_q == FullCnt) ? StDone : StIssue;
        end
      end
      StDone: begin
        if (start_i) state_d = StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      lfsr_q    <= LfsrSeed;
      gap_q     <= '0;
      acc_cnt_q <= '0;
      err_q     <= '0;
      valid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        lfsr_q    <= LfsrSeed;
        gap_q     <= '0;
        acc_cnt_q <= '0;
        err_q     <= '0;
        valid_q   <= '0;
      end else if (issue) begin
        lfsr_q    <= lfsr_next;
        gap_q     <= '0;
        acc_cnt_q <= acc_cnt_q + CntW'(1);
        if (err_event && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
        if (!illegal_csr_insn_i) valid_q[idx] <= 1'b1;
      end else if (state_q == StGap) begin
        gap_q <= gap_q + 4'd1;
      end
    end
  end

  // NOTE: the shadow array has no reset; its valid bits are reset instead and gate every read.
  always_ff @(posedge clk_i) begin
    if (issue && !illegal_csr_insn_i) shadow_q[idx] <= shadow_new;
  end

`ifdef CSR_STIM_FIRST_ERR_EN
  logic [11:0] fe_addr_q;
  logic [31:0] fe_exp_q;
  logic [31:0] fe_got_q;
  logic        fe_vld_q;

  // Illegal accesses carry no data, so exp/got are recorded as zero for them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
      fe_vld_q  <= 1'b0;
    end else if (start_ok) begin
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
      fe_vld_q  <= 1'b0;
    end else if (err_event && !fe_vld_q) begin
      fe_addr_q <= acc_addr;
      fe_exp_q  <= illegal_csr_insn_i ? 32'h0 : shadow_old;
      fe_got_q  <= illegal_csr_insn_i ? 32'h0 : csr_rdata_i;
      fe_vld_q  <= 1'b1;
    end
  end

  assign first_err_addr_o = fe_addr_q;
  assign first_err_exp_o  = fe_exp_q;
  assign first_err_got_o  = fe_got_q;
  assign first_err_vld_o  = fe_vld_q;
`endif

  assign csr_access_o   = issue;
  assign csr_op_en_o    = issue;
  assign csr_addr_o     = issue ? acc_addr : 12'h0;
  assign csr_op_o       = issue ? lfsr_q[9:8] : 2'b00;
  assign csr_wdata_o    = issue ? acc_wdata : 32'h0;
  assign busy_o         = issue || (state_q == StGap);
  assign done_o         = (state_q == StDone);
  assign test_passed_o  = done_o && (err_q == 16'h0);
  assign err_count_o    = err_q;
  assign access_count_o = acc_cnt_q;

endmodule

// File: tb/tb_csr_stim_checker.sv
// Directed bench for csr_stim_checker: two instances (full mask, gap=1; half mask, gap=0) driving
// small register-file models with optional stuck-bit, illegal-access and mask-ignoring faults.

module tb_csr_stim_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, acc_a, op_en_a, ill_a, busy_a, done_a, pass_a;
  logic [11:0] addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic [1:0]  op_a;
  logic [15:0] err_a;
  logic [4:0]  cnt_a;

  logic        start_b, acc_b, op_en_b, ill_b, busy_b, done_b, pass_b;
  logic [11:0] addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic [1:0]  op_b;
  logic [15:0] err_b;
  logic [4:0]  cnt_b;

`ifdef CSR_STIM_FIRST_ERR_EN
  logic [11:0] fe_addr_a, fe_addr_b;
  logic [31:0] fe_exp_a, fe_got_a, fe_exp_b, fe_got_b;
  logic        fe_vld_a, fe_vld_b;
`endif

  csr_stim_checker #(.NumAccesses(16), .NumShadow(8), .GapCycles(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
    .csr_access_o(acc_a), .csr_addr_o(addr_a), .csr_wdata_o(wdata_a), .csr_op_o(op_a),
    .csr_op_en_o(op_en_a), .csr_rdata_i(rdata_a), .illegal_csr_insn_i(ill_a),
    .busy_o(busy_a), .done_o(done_a), .test_passed_o(pass_a), .err_count_o(err_a),
`ifdef CSR_STIM_FIRST_ERR_EN
    .first_err_addr_o(fe_addr_a), .first_err_exp_o(fe_exp_a),
    .first_err_got_o(fe_got_a), .first_err_vld_o(fe_vld_a),
`endif
    .access_count_o(cnt_a)
  );

  csr_stim_checker #(.NumAccesses(16), .NumShadow(8), .WrMask(32'h0000_FFFF), .GapCycles(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
    .csr_access_o(acc_b), .csr_addr_o(addr_b), .csr_wdata_o(wdata_b), .csr_op_o(op_b),
    .csr_op_en_o(op_en_b), .csr_rdata_i(rdata_b), .illegal_csr_insn_i(ill_b),
    .busy_o(busy_b), .done_o(done_b), .test_passed_o(pass_b), .err_count_o(err_b),
`ifdef CSR_STIM_FIRST_ERR_EN
    .first_err_addr_o(fe_addr_b), .first_err_exp_o(fe_exp_b),
    .first_err_got_o(fe_got_b), .first_err_vld_o(fe_vld_b),
`endif
    .access_count_o(cnt_b)
  );

  // Register-file models
  logic [31:0] regs_a [8];
  logic [31:0] regs_b [8];
  logic [2:0]  idx_a, idx_b;
  logic        stuck_a, ill_arm_a, honour_b;
  logic [31:0] mask_b;

  function automatic logic [31:0] model_op(input logic [31:0] old, input logic [1:0] op,
                                           input logic [31:0] wd, input logic [31:0] mask);
    case (op)
      2'd1:    return (old & ~mask) | (wd & mask);
      2'd2:    return old | (wd & mask);
      2'd3:    return old & ~(wd & mask);
      default: return old;
    endcase
  endfunction

  always_comb begin
    idx_a   = 3'(addr_a - 12'h7C0);
    idx_b   = 3'(addr_b - 12'h7C0);
    rdata_a = regs_a[idx_a];
    if (stuck_a && idx_a == 3'd3) rdata_a = regs_a[idx_a] & ~32'h1;
    rdata_b = regs_b[idx_b];
    mask_b  = honour_b ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  end

  assign ill_a = ill_arm_a && acc_a && (cnt_a == 5'd4);
  assign ill_b = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_a[i] <= 32'h5A5A_0000 | 32'(i);
        regs_b[i] <= 32'hA5A5_0000 | 32'(i);
      end
    end else begin
      if (acc_a && !ill_a) regs_a[idx_a] <= model_op(regs_a[idx_a], op_a, wdata_a, 32'hFFFF_FFFF);
      if (acc_b && !ill_b) regs_b[idx_b] <= model_op(regs_b[idx_b], op_b, wdata_b, mask_b);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;
  int done_k;
  logic [45:0] seq [4][16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One run on instance A; k counts negedges after the start cycle.
  task automatic run_a(input int r, input bit gap_pulse);
    int j = 0;
    busy_cnt = 0;
    done_k   = 0;
    start_a  = 1'b1;
    for (int k = 1; k <= 60 && done_k == 0; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (busy_a) busy_cnt++;
      if (done_a) done_k = k;
      if (acc_a && j < 16) begin
        seq[r][j] = {addr_a, op_a, wdata_a};
        j++;
      end
      if (gap_pulse && k == 5) check("gap_start_ignored_cnt", 64'(cnt_a), 64'd2);
      if (gap_pulse && k == 4) start_a = 1'b1;
    end
  endtask

  task automatic run_b();
    bit seen = 1'b0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = done_b;
    end
    check("b_done_reached", 64'(seen), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    stuck_a = 1'b0; ill_arm_a = 1'b0; honour_b = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs_a",
          64'({acc_a, op_en_a, busy_a, done_a, pass_a, addr_a, op_a, wdata_a, err_a, cnt_a}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal run: timing, counts and the hand-decoded LFSR accesses 1, 2 and 14
    run_a(0, 1'b0);
    check("ideal_busy_cycles", 64'(busy_cnt), 64'd32);
    check("ideal_done_cycle", 64'(done_k), 64'd33);
    check("ideal_access_count", 64'(cnt_a), 64'd16);
    check("ideal_err_count", 64'(err_a), 64'd0);
    check("ideal_passed", 64'({pass_a, busy_a}), 64'b10);
    check("seq_access1", 64'(seq[0][0]), 64'({12'h7C3, 2'd1, 32'h2D5B_ACE1}));
    check("seq_access2", 64'(seq[0][1]), 64'({12'h7C6, 2'd2, 32'h96AE_D650}));
    check("seq_access14", 64'(seq[0][13]), 64'({12'h7C3, 2'd1, 32'hED0B_CE1E}));

    // Restart from DONE with an illegal 5th access and a start pulse during GAP
    ill_arm_a = 1'b1;
    run_a(1, 1'b1);
    ill_arm_a = 1'b0;
    check("illegal_done_cycle", 64'(done_k), 64'd33);
    check("illegal_access_count", 64'(cnt_a), 64'd16);
    check("illegal_err_count", 64'(err_a), 64'd1);
    check("illegal_passed", 64'(pass_a), 64'd0);
    for (int j = 0; j < 16; j++) check($sformatf("restart_seq_%0d", j), 64'(seq[1][j]), 64'(seq[0][j]));

    // Bit 0 of entry 3 stuck at 0 on reads: entry 3 is written at access 1 and revisited at 14
    stuck_a = 1'b1;
    run_a(2, 1'b0);
    stuck_a = 1'b0;
    check("stuck_err_nonzero", 64'(err_a != 16'h0), 64'd1);
    check("stuck_passed", 64'({done_a, pass_a}), 64'b10);
`ifdef CSR_STIM_FIRST_ERR_EN
    check("stuck_fe_addr", 64'(fe_addr_a), 64'h7C3);
    check("stuck_fe_diff", 64'(fe_exp_a ^ fe_got_a), 64'h1);
    check("stuck_fe_vld", 64'(fe_vld_a), 64'd1);
`endif

    // Half-width write mask: a mask-honouring model passes, a full-width model fails
    honour_b = 1'b1;
    run_b();
    check("mask_honour_err", 64'(err_b), 64'd0);
    check("mask_honour_passed", 64'(pass_b), 64'd1);
    honour_b = 1'b0;
    run_b();
    check("mask_ignored_err_nonzero", 64'(err_b != 16'h0), 64'd1);
    check("mask_ignored_passed", 64'(pass_b), 64'd0);

    // Reset for one cycle during access 7, then replay
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_access7", 64'({acc_a, cnt_a}), 64'({1'b1, 5'd6}));
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             64'({acc_a, op_en_a, busy_a, done_a, pass_a, addr_a, op_a, wdata_a, err_a, cnt_a}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'({busy_a, done_a, acc_a}), 64'd0);
    run_a(3, 1'b0);
    check("replay_done_cycle", 64'(done_k), 64'd33);
    check("replay_passed", 64'(pass_a), 64'd1);
    for (int j = 0; j < 16; j++) check($sformatf("replay_seq_%0d", j), 64'(seq[3][j]), 64'(seq[0][j]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_stim_checker.md
Name: csr_stim_checker

Overview:
- Synthesizable, self-checking CSR traffic engine for ibex_cs_registers-style CSR ports.
- Issues a pseudo-random sequence of read/write/set/clear accesses over a parametrised address window.
- Keeps a shadow model of every register in the window and compares read data against it.
- Reports pass/fail and error counts; usable in FPGA bring-up and as a DPI-free bench stimulus source.

Parameters:
- NumAccesses, 256: accesses per run, >=1.
- NumShadow, 8: registers in the window; power of two, 2..64.
- AddrBase, 12'h7C0: CSR address of window entry 0.
- WrMask, 32'hFFFF_FFFF: writable bits, common to all entries.
- GapCycles, 0: idle cycles inserted after each access, 0..15.
- LfsrSeed, 32'hACE1_2D5B: LFSR reset/restart value; nonzero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; honoured in IDLE or DONE only.
- csr_access_o  out  1  CSR access strobe.
- csr_addr_o  out  12  CSR address.
- csr_wdata_o  out  32  CSR write data.
- csr_op_o  out  2  0=READ, 1=WRITE, 2=SET, 3=CLEAR.
- csr_op_en_o  out  1  operation enable.
- csr_rdata_i  in  32  CSR read data; combinational, same cycle as the access.
- illegal_csr_insn_i  in  1  illegal-access flag, same cycle as the access.
- busy_o  out  1  run in progress.
- done_o  out  1  run complete, held until restart or reset.
- test_passed_o  out  1  done_o and err_count_o==0.
- err_count_o  out  16  saturating error count (stops at 16'hFFFF).
- access_count_o  out  CntW  completed accesses; CntW=$clog2(NumAccesses+1).

Behaviour:
- Reset (async assert, sync deassert in enclosing logic):
  - All outputs 0; FSM=IDLE; LFSR=LfsrSeed; all shadow valid bits cleared.
  - Reset mid-run aborts immediately; no partial state survives.
- FSM states IDLE, ISSUE, GAP, DONE:
  - IDLE: start_i -> ISSUE next cycle.
  - ISSUE: one cycle; drive csr_access_o=1, csr_op_en_o=1, addr/op/wdata from the current LFSR.
  - After ISSUE: -> GAP if GapCycles>0 (counter runs GapCycles cycles), else straight to the next ISSUE.
  - After access NumAccesses: -> DONE instead of another ISSUE.
  - DONE: done_o=1, busy_o=0.
  - start_i in DONE: reseed LFSR, clear counters and valid bits, -> ISSUE.
  - start_i in ISSUE/GAP is ignored.
- busy_o=1 in ISSUE and GAP only. CSR outputs are 0 outside ISSUE.
- LFSR and access fields:
  - 32-bit Galois, polynomial 0x80200003; advances once per ISSUE, after use.
  - idx = lfsr[IdxW-1:0], IdxW=$clog2(NumShadow).
  - csr_addr_o = AddrBase + idx (12-bit wrap).
  - csr_op_o = lfsr[9:8].
  - csr_wdata_o = {lfsr[15:0], lfsr[31:16]}.
- Checking in the ISSUE cycle, against the pre-operation value:
  - illegal_csr_insn_i=1: error+1; shadow unchanged; no data compare.
  - Entry valid: csr_rdata_i != shadow[idx] -> error+1. On mismatch, shadow keeps the model value, never the DUT value.
  - Entry invalid (learning): capture csr_rdata_i into shadow[idx], set valid, no compare.
- Shadow update (legal access only), starting from old = shadow[idx] (or the captured rdata):
  - WRITE: new = (old & ~WrMask) | (wdata & WrMask).
  - SET: old | (wdata & WrMask).
  - CLEAR: old & ~(wdata & WrMask).
  - READ: unchanged.
- access_count_o increments at the end of each ISSUE cycle.
- Timing: start_i sampled at cycle t -> first ISSUE at t+1 -> done_o first high at t+1+NumAccesses*(1+GapCycles).
- Error and access counters are only cleared by reset or restart.

Optional Feature:
- Macro: CSR_STIM_FIRST_ERR_EN.
- Defined: adds outputs first_err_addr_o (12), first_err_exp_o (32), first_err_got_o (32), first_err_vld_o (1).
  - They capture the first error of the run; for an illegal error, exp=got=0.
  - Sticky until restart or reset; all reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Ideal 8-entry register-file model, NumAccesses=16, GapCycles=1, start at t -> busy_o high t+1..t+32; done_o=1 at t+33; access_count_o=16; err_count_o=0; test_passed_o=1.
- Model with bit 0 of entry 3 stuck at 0 -> err_count_o>=1, test_passed_o=0; with the macro, first_err_addr_o=12'h7C3 and exp/got differ in bit 0 only.
- illegal_csr_insn_i forced high for exactly the 5th access -> err_count_o=1; a following read of the same entry matches the pre-5th-access value.
- rst_ni low for 1 cycle during access 7 -> all outputs 0 asynchronously; FSM IDLE; a new start_i replays an identical csr_addr_o/op/wdata sequence.
- start_i pulsed during GAP -> ignored, access_count_o unaffected; start_i in DONE -> counters cleared, same sequence reissued.
- WrMask=32'h0000_FFFF with a model honouring the mask -> pass; with a model writing all 32 bits -> err_count_o>0.
